// File: rtl/mire_gen_if.sv
// Wishbone master-side bundle used by the framebuffer pattern generator.
interface wshb_if;
  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    input  clk, rst, ack,
    output adr, dat_ms, stb, cyc, we, sel, cti, bte
  );
endinterface

// File: rtl/mire_gen.sv
// Test-pattern generator: writes one raster-ordered frame of 32'h00RRGGBB pixels
// into the framebuffer as incrementing Wishbone bursts, single-shot or continuous.
module mire_gen #(
  parameter int unsigned HDISP    = 800,
  parameter int unsigned VDISP    = 480,
  parameter int unsigned BURST    = 64,
  parameter int unsigned STRIPE   = 16,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  wshb_if.master      wshb_ifm,
  input  logic        enable,
  input  logic [2:0]  mode,
  input  logic [23:0] color,
  output logic        busy,
  output logic        frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int SW = $clog2(STRIPE);
  localparam int unsigned NB = HDISP / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NB - 1);

  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, nx;
  logic [YW-1:0] y_q, y_d, ny;
  logic [BW-1:0] beat_q, beat_d, nbeat;
  logic [2:0]    bar_q, bar_d, nbar;
  logic [CW-1:0] bcnt_q, bcnt_d, nbcnt;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic [2:0]    cti_q, cti_d, mode_q, mode_d;
  logic [23:0]   color_q, color_d;
  logic          stb_q, stb_d, busy_q, busy_d, done_q, done_d;
  logic          last_pix, last_beat, next_last;
  logic [23:0]   start_pix;

  function automatic logic [23:0] pix(input logic [2:0] m, input logic [23:0] c,
                                      input logic [XW-1:0] x, input logic [YW-1:0] y,
                                      input logic [2:0] bar);
    logic [31:0] xe, ye, chk;
    xe  = 32'(x);
    ye  = 32'(y);
    chk = (xe >> SW) ^ (ye >> SW);
    case (m)
      3'd0: return (xe[SW-1:0] == '0) ? 24'hFFFFFF : 24'h000000;
      3'd1: return (ye[SW-1:0] == '0) ? 24'hFFFFFF : 24'h000000;
      3'd2: return (chk[0] == 1'b0) ? 24'hFFFFFF : 24'h000000;
      3'd3: begin
        case (bar)
          3'd0:    return 24'hFFFFFF;
          3'd1:    return 24'hFFFF00;
          3'd2:    return 24'h00FFFF;
          3'd3:    return 24'h00FF00;
          3'd4:    return 24'hFF00FF;
          3'd5:    return 24'hFF0000;
          3'd6:    return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      3'd4:    return c;
      3'd5:    return {3{xe[7:0]}};
      default: return 24'h000000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    beat_d  = beat_q;
    bar_d   = bar_q;
    bcnt_d  = bcnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cti_d   = cti_q;
    mode_d  = mode_q;
    color_d = color_q;
    stb_d   = stb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
    last_beat = (beat_q == B_LAST);
    start_pix = pix(mode, color, '0, '0, '0);

    // Bar index tracks a column counter so colour bars need no divider.
    if (x_q == X_LAST) begin
      nx    = '0;
      ny    = y_q + 1'b1;
      nbar  = '0;
      nbcnt = '0;
    end else begin
      nx = x_q + 1'b1;
      ny = y_q;
      if (bcnt_q == C_LAST) begin
        nbcnt = '0;
        nbar  = bar_q + 1'b1;
      end else begin
        nbcnt = bcnt_q + 1'b1;
        nbar  = bar_q;
      end
    end
    nbeat     = last_beat ? '0 : beat_q + 1'b1;
    next_last = (nx == X_LAST) && (ny == Y_LAST);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          mode_d  = mode;
          color_d = color;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
          adr_d   = BASE_ADR;
          dat_d   = {8'h00, start_pix};
          cti_d   = CTI_INC;
          x_d     = '0;
          y_d     = '0;
          beat_d  = '0;
          bar_d   = '0;
          bcnt_d  = '0;
        end
      end
      RUN: begin
        if (wshb_ifm.ack) begin
          if (last_pix) begin
            // Frame end takes priority over an end-of-burst on the same ack.
            done_d = 1'b1;
            stb_d  = 1'b0;
            adr_d  = BASE_ADR;
            dat_d  = {8'h00, start_pix};
            cti_d  = CTI_INC;
            x_d    = '0;
            y_d    = '0;
            beat_d = '0;
            bar_d  = '0;
            bcnt_d = '0;
            if (enable) begin
              state_d = GAP;
              mode_d  = mode;
              color_d = color;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            x_d    = nx;
            y_d    = ny;
            bar_d  = nbar;
            bcnt_d = nbcnt;
            beat_d = nbeat;
            adr_d  = adr_q + 32'd4;
            dat_d  = {8'h00, pix(mode_q, color_q, nx, ny, nbar)};
            cti_d  = ((nbeat == B_LAST) || next_last) ? CTI_END : CTI_INC;
            if (last_beat) begin
              state_d = GAP;
              stb_d   = 1'b0;
            end
          end
        end
      end
      GAP: begin
        state_d = RUN;
        stb_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
    if (wshb_ifm.rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
      bar_q   <= '0;
      bcnt_q  <= '0;
      adr_q   <= BASE_ADR;
      dat_q   <= '0;
      cti_q   <= '0;
      mode_q  <= '0;
      color_q <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      beat_q  <= beat_d;
      bar_q   <= bar_d;
      bcnt_q  <= bcnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cti_q   <= cti_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = dat_q;
  assign wshb_ifm.stb    = stb_q;
  assign wshb_ifm.cyc    = stb_q;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = '1;
  assign wshb_ifm.cti    = cti_q;
  assign wshb_ifm.bte    = '0;
  assign busy            = busy_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_mire_gen.sv
// Scoreboard bench for mire_gen: three configurations share one clock and take turns;
// stimulus queues expected beats, a negedge monitor pops and compares them.
module tb_mire_gen;

  localparam int ND = 3;

  function automatic int unsigned cfg_hd(input int d); return (d == 2) ? 8 : 16; endfunction
  function automatic int unsigned cfg_vd(input int d); return (d == 2) ? 8 : 4;  endfunction
  function automatic int unsigned cfg_bu(input int d); return (d == 1) ? 6 : 8;  endfunction
  function automatic int unsigned cfg_st(input int d); return 4;                 endfunction
  function automatic logic [31:0] cfg_base(input int d);
    return (d == 2) ? 32'h0000_1000 : 32'h0;
  endfunction

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } exp_t;

  logic        clk, rst, ack, enable;
  logic [2:0]  mode;
  logic [23:0] color;
  int          act;
  bit          ack_rnd;

  logic        stb_a[ND], cyc_a[ND], we_a[ND], busy_a[ND], done_a[ND];
  logic [31:0] adr_a[ND], dat_a[ND];
  logic [2:0]  cti_a[ND];
  logic [3:0]  sel_a[ND];
  logic [1:0]  bte_a[ND];

  exp_t        exp_q[$];
  logic [31:0] cap[128];
  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, acks_frame = 0, burst_len = 0, gaps = 0, cti7 = 0;
  int last_acks = 0, last_gaps = 0, last_cti7 = 0, last_burst = 0;
  bit prev_stb = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wshb_if bus ();
    assign bus.clk = clk;
    assign bus.rst = rst;
    assign bus.ack = ack;
    mire_gen #(
      .HDISP(cfg_hd(g)), .VDISP(cfg_vd(g)), .BURST(cfg_bu(g)),
      .STRIPE(cfg_st(g)), .BASE_ADR(cfg_base(g))
    ) u_dut (
      .wshb_ifm   (bus.master),
      .enable     (enable && (act == g)),
      .mode       (mode),
      .color      (color),
      .busy       (busy_a[g]),
      .frame_done (done_a[g])
    );
    assign stb_a[g] = bus.stb;
    assign cyc_a[g] = bus.cyc;
    assign we_a[g]  = bus.we;
    assign sel_a[g] = bus.sel;
    assign bte_a[g] = bus.bte;
    assign adr_a[g] = bus.adr;
    assign dat_a[g] = bus.dat_ms;
    assign cti_a[g] = bus.cti;
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  function automatic logic [23:0] model_pix(input int d, input logic [2:0] m,
                                            input logic [23:0] c, input int x, input int y);
    int st, bw;
    logic [7:0] g8;
    st = int'(cfg_st(d));
    bw = int'(cfg_hd(d)) / 8;
    g8 = 8'(x);
    case (m)
      3'd0: return (x % st == 0) ? 24'hFFFFFF : 24'h0;
      3'd1: return (y % st == 0) ? 24'hFFFFFF : 24'h0;
      3'd2: return ((((x / st) ^ (y / st)) % 2) == 0) ? 24'hFFFFFF : 24'h0;
      3'd3: begin
        case (x / bw)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      3'd4: return c;
      3'd5: return {g8, g8, g8};
      default: return 24'h0;
    endcase
  endfunction

  task automatic push_frame(input int d, input logic [2:0] m, input logic [23:0] c);
    int hd, n, bu;
    exp_t e;
    hd = int'(cfg_hd(d));
    n  = hd * int'(cfg_vd(d));
    bu = int'(cfg_bu(d));
    for (int i = 0; i < n; i++) begin
      e.adr = cfg_base(d) + 32'(4 * i);
      e.dat = {8'h00, model_pix(d, m, c, i % hd, i / hd)};
      e.cti = (((i % bu) == bu - 1) || (i == n - 1)) ? 3'b111 : 3'b010;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic wait_acks(input int n);
    int t = 0;
    while (acks_frame < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("ack_timeout", acks_frame >= n, 1);
  endtask

  task automatic check_frame(input int d, input bit cont);
    int n, b, nb;
    n  = int'(cfg_hd(d) * cfg_vd(d));
    b  = int'(cfg_bu(d));
    nb = (n + b - 1) / b;
    chk("frame_acks", last_acks, n);
    chk("frame_gaps", last_gaps, nb - 1 + (cont ? 1 : 0));
    chk("frame_cti_end", last_cti7, nb);
    chk("last_burst_len", last_burst, (n % b == 0) ? b : n % b);
  endtask

  task automatic run_single(input int d, input logic [2:0] m, input logic [23:0] c, input bit rnd);
    int target;
    act = d; ack_rnd = rnd; mode = m; color = c;
    push_frame(d, m, c);
    target = done_cnt + 1;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    wait_done(target);
    repeat (3) @(negedge clk);
    chk("busy_after_frame", busy_a[d], 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("single_done_pulse", done_cnt, target);
    check_frame(d, 1'b0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ack = ack_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    int a;
    if (rst) begin
      acks_frame = 0; burst_len = 0; gaps = 0; cti7 = 0; prev_stb = 0;
    end else begin
      a = act;
      if (stb_a[a]) begin
        if (exp_q.size() == 0) begin
          chk("write_expected", 0, 1);
        end else begin
          e = exp_q[0];
          chk("beat", {adr_a[a], dat_a[a], cti_a[a], cyc_a[a], we_a[a], sel_a[a], bte_a[a]},
                      {e.adr, e.dat, e.cti, 1'b1, 1'b1, 4'hF, 2'b00});
          if (ack) begin
            cap[acks_frame[6:0]] = dat_a[a];
            if (cti_a[a] == 3'b111) cti7++;
            acks_frame++;
            burst_len++;
            void'(exp_q.pop_front());
          end
        end
        prev_stb = 1;
      end else begin
        if (busy_a[a]) begin
          chk("gap_len", prev_stb, 1);
          chk("gap_pos", ((acks_frame % int'(cfg_bu(a))) == 0) || done_a[a], 1);
          gaps++;
          if (!done_a[a]) burst_len = 0;
        end
        prev_stb = 0;
      end
      if (done_a[a]) begin
        done_cnt++;
        last_acks = acks_frame; last_gaps = gaps; last_cti7 = cti7; last_burst = burst_len;
        acks_frame = 0; gaps = 0; cti7 = 0; burst_len = 0;
      end
    end
  end

  initial begin
    int target;
    rst = 1'b1; enable = 1'b0; mode = '0; color = '0; act = 0; ack_rnd = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_stb", stb_a[d], 0);
      chk("rst_cyc", cyc_a[d], 0);
      chk("rst_adr", adr_a[d], cfg_base(d));
      chk("rst_dat", dat_a[d], 0);
      chk("rst_cti", cti_a[d], 0);
      chk("rst_busy", busy_a[d], 0);
      chk("rst_done", done_a[d], 0);
    end
    rst = 1'b0;

    // vertical stripes, ack tied high, then with random stalls
    run_single(0, 3'd0, 24'h0, 1'b0);
    chk("m0_x0", cap[0], 32'h00FFFFFF);
    chk("m0_x3", cap[3], 32'h0);
    chk("m0_x12", cap[12], 32'h00FFFFFF);
    chk("m0_x0y1", cap[16], 32'h00FFFFFF);
    run_single(0, 3'd0, 24'h0, 1'b1);

    run_single(0, 3'd3, 24'h0, 1'b1);
    chk("bars_x2", cap[2], 32'h00FFFF00);
    chk("bars_x14", cap[14], 32'h0);
    run_single(0, 3'd6, 24'h0, 1'b0);

    run_single(2, 3'd2, 24'h0, 1'b1);
    chk("chk_0_0", cap[0], 32'h00FFFFFF);
    chk("chk_4_0", cap[4], 32'h0);
    chk("chk_4_4", cap[36], 32'h00FFFFFF);
    chk("chk_0_4", cap[32], 32'h0);
    run_single(2, 3'd1, 24'h0, 1'b0);
    chk("hstripe_y4", cap[32], 32'h00FFFFFF);
    chk("hstripe_y1", cap[8], 32'h0);
    run_single(2, 3'd5, 24'h0, 1'b1);
    chk("grey_x5", cap[13], 32'h00050505);
    run_single(2, 3'd3, 24'h0, 1'b0);

    // continuous: mode change mid-frame applies only from the next frame
    act = 0; ack_rnd = 1'b1; mode = 3'd0; color = 24'h0;
    push_frame(0, 3'd0, 24'h0);
    push_frame(0, 3'd4, 24'h123456);
    target = done_cnt;
    @(negedge clk); enable = 1'b1;
    wait_acks(20);
    mode = 3'd4; color = 24'h123456;
    wait_done(target + 1);
    check_frame(0, 1'b1);
    wait_acks(5);
    mode = 3'd1; enable = 1'b0;
    wait_done(target + 2);
    repeat (3) @(negedge clk);
    chk("cont_busy_after", busy_a[0], 0);
    chk("cont_queue_drained", exp_q.size(), 0);
    check_frame(0, 1'b0);

    // BURST=6: short last burst and frame-end gap
    act = 1; ack_rnd = 1'b0; mode = 3'd0; color = 24'h0;
    push_frame(1, 3'd0, 24'h0);
    push_frame(1, 3'd0, 24'h0);
    target = done_cnt;
    @(negedge clk); enable = 1'b1;
    wait_done(target + 1);
    enable = 1'b0;
    check_frame(1, 1'b1);
    wait_done(target + 2);
    repeat (3) @(negedge clk);
    chk("b6_busy_after", busy_a[1], 0);
    chk("b6_queue_drained", exp_q.size(), 0);
    check_frame(1, 1'b0);

    // asynchronous reset mid-burst, then restart from pixel 0
    act = 0; ack_rnd = 1'b1; mode = 3'd0; color = 24'h0;
    push_frame(0, 3'd0, 24'h0);
    @(negedge clk); enable = 1'b1;
    wait_acks(10);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_stb", stb_a[0], 0);
    chk("mid_rst_cyc", cyc_a[0], 0);
    chk("mid_rst_adr", adr_a[0], 32'h0);
    chk("mid_rst_busy", busy_a[0], 0);
    exp_q.delete();
    push_frame(0, 3'd0, 24'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    target = done_cnt + 1;
    wait_acks(1);
    enable = 1'b0;
    wait_done(target);
    repeat (3) @(negedge clk);
    chk("rst_restart_busy", busy_a[0], 0);
    chk("rst_restart_drained", exp_q.size(), 0);
    check_frame(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
